// File: rtl/snax_cgra_tcdm_bridge_pkg.sv
// Shared TCDM reqrsp payload types for the CGRA data-memory bridge.
package snax_cgra_tcdm_bridge_pkg;

    localparam int unsigned TcdmDataWidth = 64;
    localparam int unsigned TcdmAddrWidth = 48;
    localparam int unsigned TcdmStrbWidth = TcdmDataWidth / 8;
    localparam int unsigned CoreIdWidth   = 5;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [CoreIdWidth-1:0] core_id;
        logic                   is_core;
    } tcdm_user_t;

    typedef struct packed {
        logic [TcdmAddrWidth-1:0] addr;
        logic                     write;
        amo_op_e                  amo;
        logic [TcdmDataWidth-1:0] data;
        logic [TcdmStrbWidth-1:0] strb;
        tcdm_user_t               user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [TcdmDataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_rsp_chan_t p;
        logic           p_valid;
        logic           q_ready;
    } tcdm_rsp_t;

endpackage

// File: rtl/snax_cgra_tcdm_bridge_if.sv
// Per-port CGRA memory channels and TCDM request/response buses of the bridge.
interface snax_cgra_tcdm_bridge_if #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned AddrWidth    = 6,
    parameter int unsigned PayloadWidth = 16,
    parameter type tcdm_req_t = snax_cgra_tcdm_bridge_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t = snax_cgra_tcdm_bridge_pkg::tcdm_rsp_t
);

    logic [NumPorts-1:0]                   waddr_en_i;
    logic [NumPorts-1:0][AddrWidth-1:0]    waddr_msg_i;
    logic [NumPorts-1:0]                   waddr_rdy_o;
    logic [NumPorts-1:0]                   wdata_en_i;
    logic [NumPorts-1:0][PayloadWidth-1:0] wdata_payload_i;
    logic [NumPorts-1:0]                   wdata_pred_i;
    logic [NumPorts-1:0]                   wdata_rdy_o;
    logic [NumPorts-1:0]                   raddr_en_i;
    logic [NumPorts-1:0][AddrWidth-1:0]    raddr_msg_i;
    logic [NumPorts-1:0]                   raddr_rdy_o;
    logic [NumPorts-1:0]                   rdata_en_o;
    logic [NumPorts-1:0][PayloadWidth-1:0] rdata_payload_o;
    logic [NumPorts-1:0]                   rdata_pred_o;
    logic [NumPorts-1:0]                   rdata_rdy_i;
    tcdm_req_t                             tcdm_req_o [NumPorts];
    tcdm_rsp_t                             tcdm_rsp_i [NumPorts];

    // CGRA array plus TCDM interconnect side
    modport master (
        output waddr_en_i, waddr_msg_i, wdata_en_i, wdata_payload_i, wdata_pred_i,
        output raddr_en_i, raddr_msg_i, rdata_rdy_i, tcdm_rsp_i,
        input  waddr_rdy_o, wdata_rdy_o, raddr_rdy_o,
        input  rdata_en_o, rdata_payload_o, rdata_pred_o, tcdm_req_o
    );

    // Bridge side
    modport slave (
        input  waddr_en_i, waddr_msg_i, wdata_en_i, wdata_payload_i, wdata_pred_i,
        input  raddr_en_i, raddr_msg_i, rdata_rdy_i, tcdm_rsp_i,
        output waddr_rdy_o, wdata_rdy_o, raddr_rdy_o,
        output rdata_en_o, rdata_payload_o, rdata_pred_o, tcdm_req_o
    );

endinterface

// File: rtl/snax_cgra_tcdm_bridge.sv
// Bridge from CGRA data-memory channels to SNAX TCDM ports: one IDLE/REQ
// request FSM, an outstanding-read credit counter and a response FIFO per port.
module snax_cgra_tcdm_bridge #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned PayloadWidth  = 16,
    parameter int unsigned AddrWidth     = 6,
    parameter int unsigned TCDMAddrWidth = 48,
    parameter int unsigned RspDepth      = 2,
    parameter type tcdm_req_t = snax_cgra_tcdm_bridge_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t = snax_cgra_tcdm_bridge_pkg::tcdm_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [TCDMAddrWidth-1:0] base_addr_i,
    input  logic                     sign_ext_i,
    output logic                     busy_o,
    output logic                     err_o,
    snax_cgra_tcdm_bridge_if.slave   bus_if
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteShift = $clog2(StrbWidth);
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);

    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspDepth - 1);

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } state_e;

    state_e                  state_q    [NumPorts];
    state_e                  state_d    [NumPorts];
    tcdm_req_t               req_q      [NumPorts];
    tcdm_req_t               req_d      [NumPorts];
    logic [CntWidth-1:0]     cnt_q      [NumPorts];
    logic [CntWidth-1:0]     cnt_d      [NumPorts];
    logic [CntWidth-1:0]     fifo_cnt_q [NumPorts];
    logic [CntWidth-1:0]     fifo_cnt_d [NumPorts];
    logic [PtrWidth-1:0]     wr_ptr_q   [NumPorts];
    logic [PtrWidth-1:0]     wr_ptr_d   [NumPorts];
    logic [PtrWidth-1:0]     rd_ptr_q   [NumPorts];
    logic [PtrWidth-1:0]     rd_ptr_d   [NumPorts];
    logic [PayloadWidth-1:0] mem_q      [NumPorts][RspDepth];
    logic                    err_q;
    logic                    err_d;

    logic [NumPorts-1:0]                   w_rdy_c;
    logic [NumPorts-1:0]                   r_rdy_c;
    logic [NumPorts-1:0]                   w_acc_c;
    logic [NumPorts-1:0]                   r_acc_c;
    logic [NumPorts-1:0]                   push_c;
    logic [NumPorts-1:0]                   pop_c;
    logic [NumPorts-1:0][PayloadWidth-1:0] head_c;
    logic                                  busy_c;
    logic [NumPorts-1:0]                   unused_rsp_data;

    // Payload to TCDM data word, sign- or zero-extended
    function automatic logic [DataWidth-1:0] extend_payload(
        input logic [PayloadWidth-1:0] payload,
        input logic                    sign_ext
    );
        logic [DataWidth-1:0] word;
        word = DataWidth'(payload);
        if (sign_ext && payload[PayloadWidth-1]) begin
            word = word | ({DataWidth{1'b1}} << PayloadWidth);
        end
        return word;
    endfunction

    // Element address to TCDM byte address
    function automatic logic [TCDMAddrWidth-1:0] byte_addr(
        input logic [TCDMAddrWidth-1:0] base,
        input logic [AddrWidth-1:0]     msg
    );
        return base + (TCDMAddrWidth'(msg) << ByteShift);
    endfunction

    // Handshakes, request FSMs, credit counters and FIFO pointers
    always_comb begin
        w_rdy_c = '0;
        r_rdy_c = '0;
        w_acc_c = '0;
        r_acc_c = '0;
        push_c  = '0;
        pop_c   = '0;
        head_c  = '0;
        err_d   = err_q;
        for (int p = 0; p < NumPorts; p++) begin
            state_d[p]    = state_q[p];
            req_d[p]      = req_q[p];
            cnt_d[p]      = cnt_q[p];
            fifo_cnt_d[p] = fifo_cnt_q[p];
            wr_ptr_d[p]   = wr_ptr_q[p];
            rd_ptr_d[p]   = rd_ptr_q[p];

            // a complete write pair blocks the read so the write wins
            w_rdy_c[p] = (state_q[p] == StIdle) && enable_i;
            r_rdy_c[p] = w_rdy_c[p] && (cnt_q[p] < DepthCnt)
                         && !(bus_if.waddr_en_i[p] && bus_if.wdata_en_i[p]);
            w_acc_c[p] = w_rdy_c[p] && bus_if.waddr_en_i[p] && bus_if.wdata_en_i[p];
            r_acc_c[p] = r_rdy_c[p] && bus_if.raddr_en_i[p];

            // a read is still in flight when credits exceed buffered entries
            if (bus_if.tcdm_rsp_i[p].p_valid) begin
                if (cnt_q[p] > fifo_cnt_q[p]) begin
                    push_c[p] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            pop_c[p]  = (fifo_cnt_q[p] != '0) && bus_if.rdata_rdy_i[p];
            head_c[p] = mem_q[p][rd_ptr_q[p]];

            unique case (state_q[p])
                StIdle: begin
                    if (w_acc_c[p]) begin
                        if (bus_if.wdata_pred_i[p]) begin
                            state_d[p]      = StReq;
                            req_d[p].q.addr = byte_addr(base_addr_i, bus_if.waddr_msg_i[p]);
                            req_d[p].q.write = 1'b1;
                            req_d[p].q.data = extend_payload(bus_if.wdata_payload_i[p], sign_ext_i);
                            req_d[p].q.strb = {StrbWidth{1'b1}};
                            req_d[p].q.amo  = snax_cgra_tcdm_bridge_pkg::AMONone;
                            req_d[p].q.user = '0;
                        end
                    end else if (r_acc_c[p]) begin
                        state_d[p]       = StReq;
                        req_d[p].q.addr  = byte_addr(base_addr_i, bus_if.raddr_msg_i[p]);
                        req_d[p].q.write = 1'b0;
                        req_d[p].q.data  = '0;
                        req_d[p].q.strb  = '0;
                        req_d[p].q.amo   = snax_cgra_tcdm_bridge_pkg::AMONone;
                        req_d[p].q.user  = '0;
                    end
                end
                StReq: begin
                    if (bus_if.tcdm_rsp_i[p].q_ready) begin
                        state_d[p] = StIdle;
                    end
                end
                default: state_d[p] = StIdle;
            endcase
            req_d[p].q_valid = (state_d[p] == StReq);

            cnt_d[p]      = cnt_q[p] + CntWidth'(r_acc_c[p]) - CntWidth'(pop_c[p]);
            fifo_cnt_d[p] = fifo_cnt_q[p] + CntWidth'(push_c[p]) - CntWidth'(pop_c[p]);
            if (push_c[p]) begin
                wr_ptr_d[p] = (wr_ptr_q[p] == LastPtr) ? '0 : wr_ptr_q[p] + PtrWidth'(1);
            end
            if (pop_c[p]) begin
                rd_ptr_d[p] = (rd_ptr_q[p] == LastPtr) ? '0 : rd_ptr_q[p] + PtrWidth'(1);
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                state_q[p]    <= StIdle;
                req_q[p]      <= '0;
                cnt_q[p]      <= '0;
                fifo_cnt_q[p] <= '0;
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int p = 0; p < NumPorts; p++) begin
                state_q[p]    <= state_d[p];
                req_q[p]      <= req_d[p];
                cnt_q[p]      <= cnt_d[p];
                fifo_cnt_q[p] <= fifo_cnt_d[p];
                wr_ptr_q[p]   <= wr_ptr_d[p];
                rd_ptr_q[p]   <= rd_ptr_d[p];
            end
        end
    end

    // Response FIFO storage, validity tracked by fifo_cnt_q
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (push_c[p]) begin
                mem_q[p][wr_ptr_q[p]] <= bus_if.tcdm_rsp_i[p].p.data[PayloadWidth-1:0];
            end
        end
    end

    // Activity flag across all ports
    always_comb begin
        busy_c = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            busy_c = busy_c | (state_q[p] == StReq) | (cnt_q[p] != '0);
        end
    end

    // Port-side outputs
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            bus_if.tcdm_req_o[p] = req_q[p];
            unused_rsp_data[p]   = ^bus_if.tcdm_rsp_i[p].p.data;
        end
    end

    assign bus_if.waddr_rdy_o     = w_rdy_c;
    assign bus_if.wdata_rdy_o     = w_rdy_c;
    assign bus_if.raddr_rdy_o     = r_rdy_c;
    assign bus_if.rdata_en_o      = pop_c;
    assign bus_if.rdata_pred_o    = pop_c;
    assign bus_if.rdata_payload_o = head_c;
    assign busy_o                 = busy_c;
    assign err_o                  = err_q;

endmodule

// File: tb/tb_snax_cgra_tcdm_bridge.sv
// Directed bench for the CGRA/TCDM bridge with hand-computed expectations.
module tb_snax_cgra_tcdm_bridge;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [47:0] base_addr;
    logic        sign_ext;
    logic        busy;
    logic        err;

    int vectors;
    int miscompares;

    snax_cgra_tcdm_bridge_if bus ();

    snax_cgra_tcdm_bridge dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .base_addr_i (base_addr),
        .sign_ext_i  (sign_ext),
        .busy_o      (busy),
        .err_o       (err),
        .bus_if      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        base_addr   = 48'h1000;
        sign_ext    = 1'b1;
        bus.waddr_en_i      = '0;
        bus.waddr_msg_i     = '0;
        bus.wdata_en_i      = '0;
        bus.wdata_payload_i = '0;
        bus.wdata_pred_i    = '0;
        bus.raddr_en_i      = '0;
        bus.raddr_msg_i     = '0;
        bus.rdata_rdy_i     = '0;
        for (int p = 0; p < 4; p++) bus.tcdm_rsp_i[p] = '0;

        // reset values
        #12;
        chk("rst_qvalid0", 64'(bus.tcdm_req_o[0].q_valid), 64'd0);
        chk("rst_wrdy", 64'(bus.waddr_rdy_o), 64'h0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        #1;
        chk("idle_wrdy", 64'(bus.waddr_rdy_o), 64'hF);
        chk("idle_rrdy", 64'(bus.raddr_rdy_o), 64'hF);

        // write p0, sign-extended negative payload
        tick();
        bus.waddr_en_i[0] = 1'b1; bus.waddr_msg_i[0] = 6'd5;
        bus.wdata_en_i[0] = 1'b1; bus.wdata_payload_i[0] = 16'h8001; bus.wdata_pred_i[0] = 1'b1;
        bus.tcdm_rsp_i[0].q_ready = 1'b1;
        #1;
        chk("w0_rdy", 64'(bus.waddr_rdy_o[0]), 64'd1);
        chk("w0_rrdy_blocked", 64'(bus.raddr_rdy_o[0]), 64'd0);
        tick();
        bus.waddr_en_i[0] = 1'b0; bus.wdata_en_i[0] = 1'b0;
        #1;
        chk("w0_qvalid", 64'(bus.tcdm_req_o[0].q_valid), 64'd1);
        chk("w0_addr", 64'(bus.tcdm_req_o[0].q.addr), 64'h1028);
        chk("w0_data", bus.tcdm_req_o[0].q.data, 64'hFFFF_FFFF_FFFF_8001);
        chk("w0_strb", 64'(bus.tcdm_req_o[0].q.strb), 64'hFF);
        chk("w0_write", 64'(bus.tcdm_req_o[0].q.write), 64'd1);
        chk("w0_amo", 64'(bus.tcdm_req_o[0].q.amo), 64'd0);
        chk("w0_rdy_in_req", 64'(bus.waddr_rdy_o[0]), 64'd0);
        chk("w0_busy", 64'(busy), 64'd1);
        tick();
        #1;
        chk("w0_done_qvalid", 64'(bus.tcdm_req_o[0].q_valid), 64'd0);
        chk("w0_done_busy", 64'(busy), 64'd0);

        // write p0 zero-extended
        sign_ext = 1'b0;
        bus.waddr_en_i[0] = 1'b1; bus.wdata_en_i[0] = 1'b1;
        tick();
        bus.waddr_en_i[0] = 1'b0; bus.wdata_en_i[0] = 1'b0;
        #1;
        chk("w0z_data", bus.tcdm_req_o[0].q.data, 64'h0000_0000_0000_8001);
        tick();
        sign_ext = 1'b1;

        // predicate-false write: acknowledged, no traffic
        bus.waddr_en_i[0] = 1'b1; bus.wdata_en_i[0] = 1'b1; bus.wdata_pred_i[0] = 1'b0;
        #1;
        chk("wp0_rdy", 64'(bus.wdata_rdy_o[0]), 64'd1);
        tick();
        bus.waddr_en_i[0] = 1'b0; bus.wdata_en_i[0] = 1'b0;
        #1;
        chk("wp0_qvalid", 64'(bus.tcdm_req_o[0].q_valid), 64'd0);
        chk("wp0_busy", 64'(busy), 64'd0);
        tick();
        #1;
        chk("wp0_qvalid2", 64'(bus.tcdm_req_o[0].q_valid), 64'd0);

        // read p2 with q_ready held low for 4 cycles
        bus.rdata_rdy_i[2] = 1'b1;
        bus.raddr_en_i[2] = 1'b1; bus.raddr_msg_i[2] = 6'd3;
        #1;
        chk("r2_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
        tick();
        bus.raddr_en_i[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("r2_hold_qvalid", 64'(bus.tcdm_req_o[2].q_valid), 64'd1);
            chk("r2_hold_addr", 64'(bus.tcdm_req_o[2].q.addr), 64'h1018);
            if (k < 3) tick();
        end
        chk("r2_write", 64'(bus.tcdm_req_o[2].q.write), 64'd0);
        chk("r2_strb", 64'(bus.tcdm_req_o[2].q.strb), 64'd0);
        bus.tcdm_rsp_i[2].q_ready = 1'b1;
        tick();
        #1;
        chk("r2_issued", 64'(bus.tcdm_req_o[2].q_valid), 64'd0);
        chk("r2_busy_inflight", 64'(busy), 64'd1);
        bus.tcdm_rsp_i[2].p_valid = 1'b1; bus.tcdm_rsp_i[2].p.data = 64'hDEAD_0000_0000_1234;
        #1;
        chk("r2_no_bypass", 64'(bus.rdata_en_o[2]), 64'd0);
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b0;
        #1;
        chk("r2_rdata_en", 64'(bus.rdata_en_o[2]), 64'd1);
        chk("r2_payload", 64'(bus.rdata_payload_o[2]), 64'h1234);
        chk("r2_pred", 64'(bus.rdata_pred_o[2]), 64'd1);
        tick();
        #1;
        chk("r2_popped", 64'(bus.rdata_en_o[2]), 64'd0);
        chk("r2_busy_done", 64'(busy), 64'd0);

        // credit limit on p2: third read stalls until a pop
        bus.rdata_rdy_i[2] = 1'b0;
        bus.raddr_en_i[2] = 1'b1; bus.raddr_msg_i[2] = 6'd1;
        #1;
        chk("c_r1_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
        tick();
        bus.raddr_msg_i[2] = 6'd2;
        #1;
        chk("c_r1_addr", 64'(bus.tcdm_req_o[2].q.addr), 64'h1008);
        chk("c_req_rdy", 64'(bus.raddr_rdy_o[2]), 64'd0);
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b1; bus.tcdm_rsp_i[2].p.data = 64'h0000_0000_0000_AAAA;
        #1;
        chk("c_r2_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b0;
        bus.raddr_msg_i[2] = 6'd7;
        #1;
        chk("c_r2_addr", 64'(bus.tcdm_req_o[2].q.addr), 64'h1010);
        tick();
        #1;
        chk("c_r3_blocked", 64'(bus.raddr_rdy_o[2]), 64'd0);
        bus.tcdm_rsp_i[2].p_valid = 1'b1; bus.tcdm_rsp_i[2].p.data = 64'h0000_0000_0000_BBBB;
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b0;
        #1;
        chk("c_r3_blocked2", 64'(bus.raddr_rdy_o[2]), 64'd0);
        chk("c_no_rdata", 64'(bus.rdata_en_o[2]), 64'd0);
        tick();
        #1;
        chk("c_r3_blocked3", 64'(bus.raddr_rdy_o[2]), 64'd0);
        bus.rdata_rdy_i[2] = 1'b1;
        #1;
        chk("c_pop1_en", 64'(bus.rdata_en_o[2]), 64'd1);
        chk("c_pop1_data", 64'(bus.rdata_payload_o[2]), 64'hAAAA);
        tick();
        bus.rdata_rdy_i[2] = 1'b0;
        #1;
        chk("c_r3_rdy", 64'(bus.raddr_rdy_o[2]), 64'd1);
        tick();
        bus.raddr_en_i[2] = 1'b0;
        #1;
        chk("c_r3_addr", 64'(bus.tcdm_req_o[2].q.addr), 64'h1038);
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b1; bus.tcdm_rsp_i[2].p.data = 64'h0000_0000_0000_CCCC;
        tick();
        bus.tcdm_rsp_i[2].p_valid = 1'b0;
        bus.rdata_rdy_i[2] = 1'b1;
        #1;
        chk("c_pop2_data", 64'(bus.rdata_payload_o[2]), 64'hBBBB);
        tick();
        #1;
        chk("c_pop3_data", 64'(bus.rdata_payload_o[2]), 64'hCCCC);
        chk("c_pop3_en", 64'(bus.rdata_en_o[2]), 64'd1);
        tick();
        #1;
        chk("c_drained_busy", 64'(busy), 64'd0);

        // write and read together on p1: write first
        bus.tcdm_rsp_i[1].q_ready = 1'b1;
        bus.rdata_rdy_i[1] = 1'b1;
        bus.waddr_en_i[1] = 1'b1; bus.waddr_msg_i[1] = 6'd4;
        bus.wdata_en_i[1] = 1'b1; bus.wdata_payload_i[1] = 16'h0042; bus.wdata_pred_i[1] = 1'b1;
        bus.raddr_en_i[1] = 1'b1; bus.raddr_msg_i[1] = 6'd9;
        #1;
        chk("wr_wrdy", 64'(bus.waddr_rdy_o[1]), 64'd1);
        chk("wr_rrdy", 64'(bus.raddr_rdy_o[1]), 64'd0);
        tick();
        bus.waddr_en_i[1] = 1'b0; bus.wdata_en_i[1] = 1'b0;
        #1;
        chk("wr_w_write", 64'(bus.tcdm_req_o[1].q.write), 64'd1);
        chk("wr_w_addr", 64'(bus.tcdm_req_o[1].q.addr), 64'h1020);
        chk("wr_w_data", bus.tcdm_req_o[1].q.data, 64'h42);
        chk("wr_rrdy_req", 64'(bus.raddr_rdy_o[1]), 64'd0);
        tick();
        #1;
        chk("wr_rrdy_idle", 64'(bus.raddr_rdy_o[1]), 64'd1);
        tick();
        bus.raddr_en_i[1] = 1'b0;
        #1;
        chk("wr_r_qvalid", 64'(bus.tcdm_req_o[1].q_valid), 64'd1);
        chk("wr_r_write", 64'(bus.tcdm_req_o[1].q.write), 64'd0);
        chk("wr_r_addr", 64'(bus.tcdm_req_o[1].q.addr), 64'h1048);
        tick();
        bus.tcdm_rsp_i[1].p_valid = 1'b1; bus.tcdm_rsp_i[1].p.data = 64'h55;
        tick();
        bus.tcdm_rsp_i[1].p_valid = 1'b0;
        #1;
        chk("wr_rdata", 64'(bus.rdata_payload_o[1]), 64'h55);
        tick();
        #1;
        chk("wr_busy_done", 64'(busy), 64'd0);
        chk("wr_err_clean", 64'(err), 64'd0);

        // reset while p3 waits in REQ, then a stray response
        bus.raddr_en_i[3] = 1'b1; bus.raddr_msg_i[3] = 6'd2;
        tick();
        bus.raddr_en_i[3] = 1'b0;
        #1;
        chk("mr_qvalid", 64'(bus.tcdm_req_o[3].q_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_drop", 64'(bus.tcdm_req_o[3].q_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_err", 64'(err), 64'd0);
        bus.tcdm_rsp_i[3].p_valid = 1'b1; bus.tcdm_rsp_i[3].p.data = 64'h99;
        tick();
        bus.tcdm_rsp_i[3].p_valid = 1'b0;
        #1;
        chk("stray_err", 64'(err), 64'd1);
        chk("stray_no_rdata", 64'(bus.rdata_en_o[3]), 64'd0);
        tick();
        #1;
        chk("stray_err_sticky", 64'(err), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
